// File: rtl/mips_pkg.sv
// Shared MIPS-style encoding constants used by the decoder and the assembler:
// format codes, field widths and bit positions, common opcodes, FSM states.
package mips_pkg;

   // Field widths
   localparam int OP_W    = 6;
   localparam int FUNCT_W = 6;
   localparam int REG_W   = 5;
   localparam int IMM_W   = 16;
   localparam int JT_W    = 26;

   // Least-significant bit of each field inside the 32-bit word
   localparam int OP_LSB    = 26;
   localparam int RD_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RS_LSB    = 11;
   localparam int SHAMT_LSB = 6;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_LSB   = 0;
   localparam int JT_LSB    = 0;

   // Format codes
   localparam logic [1:0] FMT_R   = 2'b00;
   localparam logic [1:0] FMT_I   = 2'b01;
   localparam logic [1:0] FMT_J   = 2'b10;
   localparam logic [1:0] FMT_BAD = 2'b11;

   // Opcode / funct values shared with the decoder
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;

   // Load-session controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } asm_state_e;

   // Raw field bundle as presented to the assembler
   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic [FUNCT_W-1:0] funct;
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   rt;
      logic [REG_W-1:0]   rd;
      logic [REG_W-1:0]   shamt;
      logic [IMM_W-1:0]   imm;
      logic [JT_W-1:0]    jtarget;
   } inst_fields_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: turns a field bundle plus format code into a 32-bit
// instruction word, the exact inverse of the team decoder. Illegal formats
// produce an all-zero word and raise illegal_o.
module inst_pack
   import mips_pkg::*;
(
   input  logic [1:0]   fmt_i,
   input  inst_fields_t fields_i,
   output logic [31:0]  word_o,
   output logic         illegal_o
);

   // Place each field at its bit position; fields a format does not use stay zero.
   always_comb begin
      word_o    = '0;
      illegal_o = 1'b0;
      case (fmt_i)
         FMT_R: begin
            word_o[OP_LSB +: OP_W]       = fields_i.op;
            word_o[RD_LSB +: REG_W]      = fields_i.rd;
            word_o[RT_LSB +: REG_W]      = fields_i.rt;
            word_o[RS_LSB +: REG_W]      = fields_i.rs;
            word_o[SHAMT_LSB +: REG_W]   = fields_i.shamt;
            word_o[FUNCT_LSB +: FUNCT_W] = fields_i.funct;
         end
         FMT_I: begin
            word_o[OP_LSB +: OP_W]   = fields_i.op;
            word_o[RD_LSB +: REG_W]  = fields_i.rd;
            word_o[RT_LSB +: REG_W]  = fields_i.rt;
            word_o[IMM_LSB +: IMM_W] = fields_i.imm;
         end
         FMT_J: begin
            word_o[OP_LSB +: OP_W] = fields_i.op;
            word_o[JT_LSB +: JT_W] = fields_i.jtarget;
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_assembler.sv
// Instruction assembler: accepts field bundles during a load session, packs
// each into a 32-bit word and writes it to consecutive instruction-memory
// addresses starting at base_addr. Writes appear one cycle after acceptance.
module inst_assembler
   import mips_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] n_words,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [15:0]       add_imm,
   input  logic [25:0]       j_add,
   input  logic              mem_busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   asm_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] remaining_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic              err_q;

   inst_fields_t      fields_d;
   logic [31:0]       word_d;
   logic              illegal_d;
   logic              accept_d;

   assign fields_d = '{op: op, funct: funct, rs: rs, rt: rt, rd: rd,
                       shamt: shamt, imm: add_imm, jtarget: j_add};

   inst_pack u_pack (
      .fmt_i     (fmt),
      .fields_i  (fields_d),
      .word_o    (word_d),
      .illegal_o (illegal_d)
   );

   // mem_busy only throttles new acceptances; a registered write always completes.
   assign in_ready = (state_q == ST_RUN) && (remaining_q != '0) && !mem_busy;
   assign accept_d = in_valid && in_ready;

   // Session FSM plus the registered memory write port and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_RUN;
                  addr_q      <= base_addr;
                  remaining_q <= n_words;
                  err_q       <= 1'b0;
               end
            end
            ST_RUN: begin
               if (accept_d) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= word_d;
                  addr_q      <= addr_q + ADDR_W'(1);
                  remaining_q <= remaining_q - ADDR_W'(1);
                  if (illegal_d) begin
                     err_q <= 1'b1;
                  end
                  // Leaving now lines DONE up with the final write.
                  if (remaining_q == ADDR_W'(1)) begin
                     state_q <= ST_DONE;
                  end
               end else if (remaining_q == '0) begin
                  // Empty session: finish straight away.
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign err       = err_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_inst_assembler.sv
// Self-checking bench for inst_assembler: every accepted bundle pushes its
// expected address/word into a queue; a monitor pops and compares each write.
module tb_inst_assembler;
   import mips_pkg::*;

   localparam int AW = 10;

   logic          clk;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] n_words;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    fmt;
   logic [5:0]    op;
   logic [5:0]    funct;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [4:0]    rd;
   logic [4:0]    shamt;
   logic [15:0]   add_imm;
   logic [25:0]   j_add;
   logic          mem_busy;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          busy;
   logic          done;
   logic          err;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   exp_t          exp_q[$];
   logic [AW-1:0] model_addr;
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;

   inst_assembler #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .n_words   (n_words),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fmt       (fmt),
      .op        (op),
      .funct     (funct),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .shamt     (shamt),
      .add_imm   (add_imm),
      .j_add     (j_add),
      .mem_busy  (mem_busy),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference encoding written straight from the format table.
   function automatic logic [31:0] pack_ref(input logic [1:0] f, input logic [5:0] o,
                                            input logic [5:0] fn, input logic [4:0] s,
                                            input logic [4:0] t, input logic [4:0] d,
                                            input logic [4:0] sh, input logic [15:0] im,
                                            input logic [25:0] ja);
      case (f)
         2'b00:   return {o, d, t, s, sh, fn};
         2'b01:   return {o, d, t, im};
         2'b10:   return {o, ja};
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Write monitor: every mem_we must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (mem_we === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               bad++;
               $display("FAIL write_check got addr=%h data=%h expected addr=%h data=%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic start_session(input logic [AW-1:0] b, input logic [AW-1:0] n);
      start     = 1'b1;
      base_addr = b;
      n_words   = n;
      @(posedge clk); #1;
      start      = 1'b0;
      base_addr  = AW'($urandom);
      n_words    = AW'($urandom);
      model_addr = b;
   endtask

   task automatic send(input logic [1:0] f, input logic [5:0] o, input logic [5:0] fn,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [4:0] sh, input logic [15:0] im, input logic [25:0] ja,
                       input logic [31:0] exp_w);
      bit   got;
      exp_t e;
      got = 1'b0;
      fmt = f; op = o; funct = fn; rs = s; rt = t; rd = d; shamt = sh;
      add_imm = im; j_add = ja;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            e.addr = model_addr;
            e.data = exp_w;
            exp_q.push_back(e);
            model_addr = model_addr + AW'(1);
            got = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if (!got) begin
         bad++;
         $display("FAIL send_timeout accepted=0 required=1");
      end
   endtask

   task automatic send_rand(input logic [1:0] f);
      logic [5:0]  o;
      logic [5:0]  fn;
      logic [4:0]  s;
      logic [4:0]  t;
      logic [4:0]  d;
      logic [4:0]  sh;
      logic [15:0] im;
      logic [25:0] ja;
      o  = 6'($urandom);  fn = 6'($urandom);
      s  = 5'($urandom);  t  = 5'($urandom);
      d  = 5'($urandom);  sh = 5'($urandom);
      im = 16'($urandom); ja = 26'($urandom);
      send(f, o, fn, s, t, d, sh, im, ja, pack_ref(f, o, fn, s, t, d, sh, im, ja));
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      start    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (mem_we !== 1'b0)     begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      total++; if (mem_addr !== '0)     begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      total++; if (mem_wdata !== '0)    begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
      total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (err !== 1'b0)        begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      @(posedge clk); #1;
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_rtype();
      start_session(10'h010, 10'd3);
      @(negedge clk);
      total++; if (busy !== 1'b1)     begin bad++; $display("FAIL run_busy got=%b exp=1", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL run_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
      send(FMT_R, OP_SPECIAL, FUNCT_ADD, 5'd3, 5'd2, 5'd1, 5'd0, 16'hBEEF, 26'h155_5555, 32'h0022_1820);
      send_rand(FMT_R);
      send_rand(FMT_R);
      @(negedge clk);
      total++; if (done !== 1'b1)   begin bad++; $display("FAIL rtype_done_last got=%b exp=1", done); end
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rtype_we_last got=%b exp=1", mem_we); end
      total++; if (mem_addr !== 10'h012) begin bad++; $display("FAIL rtype_last_addr got=%h exp=012", mem_addr); end
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL rtype_idle got done=%b busy=%b exp 0 0", done, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ij_err();
      start_session(10'h100, 10'd3);
      send(FMT_I, OP_ADDI, 6'h3F, 5'h1F, 5'd6, 5'd5, 5'h1F, 16'hFFFF, 26'h2AA_AAAA, 32'h20A6_FFFF);
      @(negedge clk);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_before_illegal got=%b exp=0", err); end
      @(posedge clk); #1;
      send(FMT_J, OP_J, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FF_FFFF, 32'h0BFF_FFFF);
      send(FMT_BAD, 6'h3F, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FF_FFFF, 32'h0000_0000);
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ij_done_last got=%b exp=1", done); end
      total++; if (err !== 1'b1)  begin bad++; $display("FAIL err_set got=%b exp=1", err); end
      repeat (3) @(negedge clk);
      total++; if (err !== 1'b1)  begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
      @(posedge clk); #1;
      // Empty session: also clears err.
      start_session(10'h1F0, 10'd0);
      @(negedge clk);
      total++; if (err !== 1'b0)  begin bad++; $display("FAIL err_cleared got=%b exp=0", err); end
      total++; if (done !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL empty_cycle1 got done=%b busy=%b exp 0 1", done, busy);
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL empty_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL empty_done got=%b exp=1", done); end
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL empty_idle got done=%b busy=%b exp 0 0", done, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      start_session(10'h3FE, 10'd3);
      send_rand(FMT_R);
      send_rand(FMT_I);
      send_rand(FMT_J);
      @(negedge clk);
      total++; if (mem_addr !== 10'h000) begin bad++; $display("FAIL wrap_addr got=%h exp=000", mem_addr); end
      total++; if (done !== 1'b1 || mem_we !== 1'b1) begin
         bad++; $display("FAIL wrap_done got done=%b we=%b exp 1 1", done, mem_we);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mem_busy();
      start_session(10'h020, 10'd4);
      send_rand(FMT_R);
      mem_busy = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         total++; if (mem_we !== (i == 0)) begin
            bad++; $display("FAIL busy_mem_we cyc=%0d got=%b exp=%b", i, mem_we, (i == 0));
         end
         @(posedge clk); #1;
      end
      mem_busy = 1'b0;
      send_rand(FMT_I);
      send_rand(FMT_J);
      send_rand(FMT_R);
      @(negedge clk);
      total++; if (done !== 1'b1 || mem_we !== 1'b1) begin
         bad++; $display("FAIL busy_done got done=%b we=%b exp 1 1", done, mem_we);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      start_session(10'h050, 10'd3);
      send_rand(FMT_R);
      start     = 1'b1;
      base_addr = 10'h200;
      n_words   = 10'd7;
      @(posedge clk); #1;
      start = 1'b0;
      send_rand(FMT_I);
      send_rand(FMT_R);
      @(negedge clk);
      total++; if (mem_addr !== 10'h052) begin bad++; $display("FAIL ignstart_addr got=%h exp=052", mem_addr); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ignstart_done got=%b exp=1", done); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignstart_idle got=%b exp=0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_rst_mid();
      start_session(10'h060, 10'd5);
      send_rand(FMT_R);
      // Reset lands while another bundle is being offered: that one must never be written.
      rst      = 1'b1;
      in_valid = 1'b1;
      fmt      = FMT_R;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (mem_we !== 1'b0)   begin bad++; $display("FAIL rst_mem_we cyc=%0d got=%b exp=0", i, mem_we); end
         total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy cyc=%0d got=%b exp=0", i, busy); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      start_session(10'h000, 10'd1);
      send_rand(FMT_J);
      @(negedge clk);
      total++; if (done !== 1'b1 || mem_we !== 1'b1) begin
         bad++; $display("FAIL rst_recover got done=%b we=%b exp 1 1", done, mem_we);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int c0;
      start_session(10'h2A0, 10'd8);
      c0 = cyc;
      for (int i = 0; i < 8; i++) begin
         send_rand(2'($urandom_range(0, 3)));
      end
      total++; if (cyc - c0 != 8) begin bad++; $display("FAIL b2b_cycles got=%0d exp=8", cyc - c0); end
      @(negedge clk);
      total++; if (done !== 1'b1 || mem_we !== 1'b1) begin
         bad++; $display("FAIL b2b_done got done=%b we=%b exp 1 1", done, mem_we);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; n_words = '0;
      in_valid = 1'b0; fmt = '0; op = '0; funct = '0; rs = '0; rt = '0;
      rd = '0; shamt = '0; add_imm = '0; j_add = '0; mem_busy = 1'b0;
      model_addr = '0;
      test_reset();
      test_rtype();
      test_ij_err();
      test_wrap();
      test_mem_busy();
      test_start_ignored();
      test_rst_mid();
      test_back_to_back();
      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain outstanding=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_assembler.md
INST_ASSEMBLER -- requirements
Module: inst_assembler

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction-memory word-address width.
REQ-002 Port: clk  in  1  rising-edge clock, sole clock.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle pulse that begins a load session.
REQ-005 Port: base_addr  in  ADDR_W  first word address of the session, sampled on start.
REQ-006 Port: n_words  in  ADDR_W  number of instructions in the session, sampled on start.
REQ-007 Port: in_valid  in  1  field bundle valid.
REQ-008 Port: in_ready  out  1  block accepts a bundle this cycle.
REQ-009 Port: fmt  in  2  format: 00 R, 01 I, 10 J, 11 illegal.
REQ-010 Port: op, funct  in  6 each  opcode and function fields.
REQ-011 Port: rs, rt, rd, shamt  in  5 each  register and shift fields.
REQ-012 Port: add_imm  in  16  I-type immediate.
REQ-013 Port: j_add  in  26  J-type target.
REQ-014 Port: mem_busy  in  1  instruction memory cannot take a write this cycle.
REQ-015 Port: mem_we  out  1  write strobe to instruction memory.
REQ-016 Port: mem_addr  out  ADDR_W  write word address.
REQ-017 Port: mem_wdata  out  32  packed instruction word.
REQ-018 Port: busy  out  1  session in progress.
REQ-019 Port: done  out  1  one-cycle pulse at session end.
REQ-020 Port: err  out  1  sticky illegal-format flag, cleared on start.

Function
REQ-021 Packing is the exact inverse of the team decoder: [31:26] op always.
REQ-022 R: [25:21] rd, [20:16] rt, [15:11] rs, [10:6] shamt, [5:0] funct.
REQ-023 I: [25:21] rd, [20:16] rt, [15:0] add_imm; rs, shamt and funct are ignored.
REQ-024 J: [25:0] j_add; all other fields except op are ignored.
REQ-025 Illegal fmt: the bundle is accepted, the word is written as 32'h0000_0000, and err is set.
REQ-026 FSM states: IDLE, RUN, DONE.
REQ-027 IDLE->RUN on start; addr_q<=base_addr, remaining<=n_words, err<=0.
REQ-028 RUN->DONE in the cycle remaining reaches 0, or the cycle after start when n_words==0.
REQ-029 DONE->IDLE unconditionally; done=1 only in DONE.
REQ-030 in_ready = (state==RUN) && (remaining!=0) && !mem_busy.
REQ-031 Accept = in_valid && in_ready; on accept, remaining decrements and addr_q increments.
REQ-032 Latency is 1 cycle: mem_we=1 with registered mem_addr (pre-increment addr_q) and mem_wdata in the cycle after accept; otherwise mem_we=0.
REQ-033 mem_addr wraps modulo 2^ADDR_W (max to 0) without error.
REQ-034 mem_busy only gates acceptance; a write already registered completes regardless.
REQ-035 start is ignored outside IDLE.
REQ-036 in_valid outside RUN is ignored; no write occurs.
REQ-037 busy=1 in RUN and DONE.
REQ-038 The final write's mem_we and done assert in the same cycle.

Reset
REQ-039 On rst: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, busy=0, in_ready=0, remaining=0.
REQ-040 rst mid-session aborts the session; a write registered that cycle is dropped (mem_we=0 next cycle).

Structure
REQ-041 Shared package mips_pkg holds the fmt codes, the field bit-position constants, and the opcode/funct constants used by both decoder and assembler.
REQ-042 One combinational sub-module, inst_pack (fields+fmt -> word, illegal flag), is instantiated once.

Verification
REQ-043 start, base_addr=0x010, n_words=3, R fmt op=0, rd=1, rt=2, rs=3, shamt=0, funct=0x20 -> mem_wdata=0x0022_1820 @0x010; next two writes @0x011/0x012; done with third write.
REQ-044 I fmt op=0x08, rd=5, rt=6, add_imm=0xFFFF -> mem_wdata=0x20A6_FFFF.
REQ-045 J fmt op=0x02, j_add=0x3FF_FFFF -> mem_wdata=0x0BFF_FFFF; fmt=11 -> word 0, err=1 until next start.
REQ-046 base_addr=0x3FE, n_words=3 -> writes at 0x3FE, 0x3FF, 0x000.
REQ-047 mem_busy high 4 cycles mid-session with in_valid held -> in_ready=0, no mem_we, no lost/duplicate words; n_words=0 -> done 2 cycles after start, no writes.
REQ-048 rst asserted the cycle after an accept -> no mem_we, state IDLE; start during RUN -> ignored, addresses unchanged.
